// File: rtl/ppam_mon_pkg.sv
// Shared types and constants for the approximate-multiplier error monitor
// and its LFSR operand generator.
package ppam_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CHECK,
    DONE
  } mon_state_t;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 32;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction

endpackage

// File: rtl/ppam_lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR with seed load; shared by the
// multiplier characterisation blocks.
module ppam_lfsr16
  import ppam_mon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      value <= seed;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/ppam_error_monitor_ctrl.sv
// Sequencer that drives LFSR operands into an 8x8 approximate multiplier,
// waits for it to settle and accumulates error statistics against the exact product.
module ppam_error_monitor_ctrl
  import ppam_mon_pkg::*;
#(
  parameter int          N_SAMPLES     = 10000,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic [15:0] sample_cnt,
  output logic [15:0] err_count,
  output logic [31:0] sum_abs_ed,
  output logic [15:0] max_ed
);

  localparam logic [15:0] N_LAST      = N_SAMPLES[15:0];
  localparam logic [7:0]  SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  mon_state_t  state;
  logic [7:0]  settle_cnt;
  logic [15:0] lfsr_value;
  logic        lfsr_load;
  logic        lfsr_step;
  logic        start_ok;
  logic [15:0] exact;
  logic [15:0] ed;
  logic [15:0] sample_next;

  // Unsigned distance without going through a signed difference.
  function automatic logic [15:0] abs_diff(input logic [15:0] x, input logic [15:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  always_comb begin
    start_ok    = start && (state == IDLE || state == DONE);
    lfsr_load   = start_ok;
    lfsr_step   = (state == LOAD) && !abort;
    exact       = {8'd0, mul_a} * {8'd0, mul_b};
    ed          = abs_diff(exact, mul_p);
    sample_next = sample_cnt + 16'd1;
  end

  ppam_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (LFSR_SEED),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      settle_cnt <= '0;
      sample_cnt <= '0;
      err_count  <= '0;
      sum_abs_ed <= '0;
      max_ed     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state      <= LOAD;
            busy       <= 1'b1;
            done       <= 1'b0;
            sample_cnt <= '0;
            err_count  <= '0;
            sum_abs_ed <= '0;
            max_ed     <= '0;
          end else if (state == DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            mul_a      <= lfsr_value[15:8];
            mul_b      <= lfsr_value[7:0];
            settle_cnt <= SETTLE_INIT;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (settle_cnt == 8'd0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        CHECK: begin
          // The sample is always accounted, even when aborting on this edge.
          if (ed != 16'd0) err_count <= err_count + 16'd1;
          sum_abs_ed <= sum_abs_ed + {16'd0, ed};
          if (ed > max_ed) max_ed <= ed;
          sample_cnt <= sample_next;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sample_next == N_LAST) begin
            state <= DONE;
          end else begin
            state <= LOAD;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppam_error_monitor_ctrl.sv
// Bench for ppam_error_monitor_ctrl: three instances (16, 8 and 1 samples) with
// behavioural multiplier models, table vectors, random runs and corner sequences.
module tb_ppam_error_monitor_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        start_v;
  logic [2:0]        abort_v;
  logic [2:0]        busy_v;
  logic [2:0]        done_v;
  logic [2:0][7:0]   a_v;
  logic [2:0][7:0]   b_v;
  logic [2:0][15:0]  p_v;
  logic [2:0][15:0]  cnt_v;
  logic [2:0][15:0]  err_v;
  logic [2:0][31:0]  sum_v;
  logic [2:0][15:0]  max_v;
  int                mode_v [3];
  int                lowmask;
  int                pat;
  int                total = 0;
  int                bad = 0;

  always #5 clk = ~clk;

  // Multiplier models: 0 exact, 1 exact+3, 2 stuck at zero, 3 low bits replaced by a pattern.
  function automatic int approx(input int a, input int b, input int mode);
    int e;
    e = a * b;
    case (mode)
      1:       return (e + 3) & 32'hFFFF;
      2:       return 0;
      3:       return (e & ~lowmask & 32'hFFFF) | (pat & lowmask);
      default: return e;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int N = (g == 0) ? 16 : (g == 1) ? 8 : 1;
    ppam_error_monitor_ctrl #(
      .N_SAMPLES    (N),
      .SETTLE_CYCLES(4),
      .LFSR_SEED    (16'hACE1)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_v[g]),
      .abort     (abort_v[g]),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .mul_a     (a_v[g]),
      .mul_b     (b_v[g]),
      .mul_p     (p_v[g]),
      .sample_cnt(cnt_v[g]),
      .err_count (err_v[g]),
      .sum_abs_ed(sum_v[g]),
      .max_ed    (max_v[g])
    );
    assign p_v[g] = 16'(approx(int'(a_v[g]), int'(b_v[g]), mode_v[g]));
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the operand sequence straight from the LFSR rule and
  // accumulate the statistics with plain integer arithmetic.
  task automatic model_run(input int n, input int mode, output int err, output int sum,
                           output int mx, output int la, output int lb);
    int v, a, b, e, p, ed, fb;
    v = 32'hACE1; err = 0; sum = 0; mx = 0; la = 0; lb = 0;
    for (int i = 0; i < n; i++) begin
      a = (v >> 8) & 255;
      b = v & 255;
      e = a * b;
      p = approx(a, b, mode);
      ed = (e > p) ? e - p : p - e;
      if (ed != 0) err++;
      sum += ed;
      if (ed > mx) mx = ed;
      la = a; lb = b;
      fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
      v = (v >> 1) | (fb << 15);
    end
  endtask

  // Pulse start on instance g and count edges until done (bounded).
  task automatic run_inst(input int g, output int lat, output int d0, output int b0);
    @(posedge clk); #1 start_v[g] = 1'b1;
    @(posedge clk); #1 start_v[g] = 1'b0;
    d0 = int'(done_v[g]);
    b0 = int'(busy_v[g]);
    lat = 0;
    while (done_v[g] !== 1'b1 && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy_v[0]), 0);
    check({tag, "_done"}, int'(done_v[0]), 0);
    check({tag, "_a"},    int'(a_v[0]), 0);
    check({tag, "_b"},    int'(b_v[0]), 0);
    check({tag, "_cnt"},  int'(cnt_v[0]), 0);
    check({tag, "_err"},  int'(err_v[0]), 0);
    check({tag, "_sum"},  int'(sum_v[0]), 0);
    check({tag, "_max"},  int'(max_v[0]), 0);
  endtask

  typedef struct {
    int inst;
    int mode;
    int exp_lat;
    int exp_cnt;
    int exp_err;
    int exp_sum;
    int exp_max;
    int chk_ops;
    int exp_a;
    int exp_b;
  } vec_t;

  vec_t tbl [3];

  initial begin
    int lat, d0, b0, e_err, e_sum, e_max, e_a, e_b, tmp;

    tbl[0] = '{inst: 0, mode: 0, exp_lat: 97, exp_cnt: 16, exp_err: 0, exp_sum: 0,
               exp_max: 0, chk_ops: 0, exp_a: 0, exp_b: 0};
    tbl[1] = '{inst: 1, mode: 1, exp_lat: 49, exp_cnt: 8, exp_err: 8, exp_sum: 24,
               exp_max: 3, chk_ops: 0, exp_a: 0, exp_b: 0};
    tbl[2] = '{inst: 2, mode: 2, exp_lat: 7, exp_cnt: 1, exp_err: 1, exp_sum: 38700,
               exp_max: 38700, chk_ops: 1, exp_a: 32'hAC, exp_b: 32'hE1};

    rst_n = 1'b0; start_v = '0; abort_v = '0;
    lowmask = 0; pat = 0;
    for (int i = 0; i < 3; i++) mode_v[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 3; i++) begin
      int g;
      g = tbl[i].inst;
      mode_v[g] = tbl[i].mode;
      run_inst(g, lat, d0, b0);
      check($sformatf("v%0d_busy_at_start", i), b0, 1);
      check($sformatf("v%0d_latency", i), lat, tbl[i].exp_lat);
      check($sformatf("v%0d_cnt", i), int'(cnt_v[g]), tbl[i].exp_cnt);
      check($sformatf("v%0d_err", i), int'(err_v[g]), tbl[i].exp_err);
      check($sformatf("v%0d_sum", i), int'(sum_v[g]), tbl[i].exp_sum);
      check($sformatf("v%0d_max", i), int'(max_v[g]), tbl[i].exp_max);
      check($sformatf("v%0d_busy_end", i), int'(busy_v[g]), 0);
      if (tbl[i].chk_ops != 0) begin
        check($sformatf("v%0d_a", i), int'(a_v[g]), tbl[i].exp_a);
        check($sformatf("v%0d_b", i), int'(b_v[g]), tbl[i].exp_b);
      end
    end

    // Random approximate models on the 16-sample instance; each run restarts from done,
    // and the last one repeats the previous configuration.
    mode_v[0] = 3;
    for (int it = 0; it < 5; it++) begin
      if (it < 4) begin
        lowmask = (1 << $urandom_range(1, 8)) - 1;
        pat = int'($urandom & 32'hFFFF);
      end
      model_run(16, 3, e_err, e_sum, e_max, e_a, e_b);
      run_inst(0, lat, d0, b0);
      check($sformatf("r%0d_done_drop", it), d0, 0);
      check($sformatf("r%0d_latency", it), lat, 97);
      check($sformatf("r%0d_cnt", it), int'(cnt_v[0]), 16);
      check($sformatf("r%0d_err", it), int'(err_v[0]), e_err);
      check($sformatf("r%0d_sum", it), int'(sum_v[0]), e_sum);
      check($sformatf("r%0d_max", it), int'(max_v[0]), e_max);
      check($sformatf("r%0d_a", it), int'(a_v[0]), e_a);
      check($sformatf("r%0d_b", it), int'(b_v[0]), e_b);
    end

    // Repeated starts mid-run are ignored; abort in SETTLE of sample 5 (edge 27).
    mode_v[0] = 1;
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    check("ab_busy", int'(busy_v[0]), 1);
    check("ab_done_clr", int'(done_v[0]), 0);
    check("ab_cnt_clr", int'(cnt_v[0]), 0);
    for (int c = 1; c <= 27; c++) begin
      start_v[0] = (c == 3 || c == 9 || c == 18);
      abort_v[0] = (c == 27);
      @(posedge clk); #1;
    end
    start_v[0] = 1'b0; abort_v[0] = 1'b0;
    model_run(4, 1, e_err, e_sum, e_max, tmp, tmp);
    model_run(5, 1, tmp, tmp, tmp, e_a, e_b);
    check("ab_busy_low", int'(busy_v[0]), 0);
    check("ab_done_low", int'(done_v[0]), 0);
    check("ab_cnt", int'(cnt_v[0]), 4);
    check("ab_err", int'(err_v[0]), e_err);
    check("ab_sum", int'(sum_v[0]), e_sum);
    check("ab_max", int'(max_v[0]), e_max);
    check("ab_a_held", int'(a_v[0]), e_a);
    check("ab_b_held", int'(b_v[0]), e_b);
    repeat (3) @(posedge clk);
    #1;
    check("ab_idle_busy", int'(busy_v[0]), 0);
    check("ab_idle_cnt", int'(cnt_v[0]), 4);

    // Restart after abort clears statistics and replays the seed operands.
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    check("rs_cnt", int'(cnt_v[0]), 0);
    check("rs_err", int'(err_v[0]), 0);
    check("rs_sum", int'(sum_v[0]), 0);
    check("rs_max", int'(max_v[0]), 0);
    @(posedge clk); #1;
    check("rs_a", int'(a_v[0]), 32'hAC);
    check("rs_b", int'(b_v[0]), 32'hE1);

    // Reset sampled on the CHECK edge of sample 2 (edge 12 after accept).
    for (int c = 2; c <= 12; c++) begin
      if (c == 12) begin
        check("pre_rst_err", int'(err_v[0]), 1);
        rst_n = 1'b0;
      end
      @(posedge clk); #1;
    end
    check_all_zero("midrst");
    rst_n = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    check("post_rst_busy", int'(busy_v[0]), 1);
    @(posedge clk); #1;
    check("post_rst_a", int'(a_v[0]), 32'hAC);
    check("post_rst_b", int'(b_v[0]), 32'hE1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
